// File: rtl/conv1d_compute_engine_pkg.sv
// Shared types and fixed-point helpers for the 1-D convolution engine.
// Optional fused ReLU is selected by CONV_RELU_EN (see conv_mac_lane).
package conv_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int DEF_BIT_WIDTH   = 16;
    localparam int DEF_FRAC_BITS   = 8;
    localparam int DEF_KERNEL_TAPS = 5;
    localparam int DEF_NUM_FILTERS = 8;
    localparam int DEF_DATA_DEPTH  = 512;
    localparam int WIDE_W          = 64;

    function automatic int acc_width(input int bw, input int taps);
        return 2 * bw + $clog2(taps + 1);
    endfunction

    function automatic logic signed [WIDE_W-1:0] sat_max(input int bw);
        return (64'sd1 <<< (bw - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [WIDE_W-1:0] sat_min(input int bw);
        return -(64'sd1 <<< (bw - 1));
    endfunction

    // Floor-shift out the fraction, then clamp to the signed bw-bit range.
    function automatic logic signed [WIDE_W-1:0] sat_shift(
        input logic signed [WIDE_W-1:0] acc,
        input int                       bw,
        input int                       frac
    );
        logic signed [WIDE_W-1:0] sh;
        sh = acc >>> frac;
        if (sh > sat_max(bw)) begin
            return sat_max(bw);
        end else if (sh < sat_min(bw)) begin
            return sat_min(bw);
        end
        return sh;
    endfunction

endpackage

// File: rtl/conv1d_compute_engine_if.sv
// Host/RAM-facing bundle of the convolution engine: launch, status, read ports
// toward the data/weight RAMs and the result RAM write port.
interface conv1d_compute_engine_if #(
    parameter int BIT_WIDTH   = 16,
    parameter int KERNEL_TAPS = 5,
    parameter int NUM_FILTERS = 8,
    parameter int DATA_DEPTH  = 512
);
    localparam int PAW = $clog2(DATA_DEPTH);
    localparam int PCW = PAW + 1;
    localparam int FAW = $clog2(NUM_FILTERS);
    localparam int FCW = FAW + 1;

    logic                                 start;
    logic [PCW-1:0]                       num_positions;
    logic [FCW-1:0]                       num_filters;
    logic                                 busy;
    logic                                 done;

    logic [PAW-1:0]                       data_ram_address;
    logic                                 data_ram_read_en;
    logic [KERNEL_TAPS*BIT_WIDTH-1:0]     data_read_out;

    logic [FAW-1:0]                       weights_ram_address;
    logic                                 weights_ram_read_en;
    logic [(KERNEL_TAPS+1)*BIT_WIDTH-1:0] weight_read_out;

    logic                                 result_ram_write_en;
    logic [FAW-1:0]                       result_ram_write_address_depth;
    logic [PAW-1:0]                       result_ram_write_address_width;
    logic [BIT_WIDTH-1:0]                 result_ram_write_data;

    modport master (
        output start, num_positions, num_filters, data_read_out, weight_read_out,
        input  busy, done, data_ram_address, data_ram_read_en,
               weights_ram_address, weights_ram_read_en,
               result_ram_write_en, result_ram_write_address_depth,
               result_ram_write_address_width, result_ram_write_data
    );

    modport slave (
        input  start, num_positions, num_filters, data_read_out, weight_read_out,
        output busy, done, data_ram_address, data_ram_read_en,
               weights_ram_address, weights_ram_read_en,
               result_ram_write_en, result_ram_write_address_depth,
               result_ram_write_address_width, result_ram_write_data
    );

endinterface

// File: rtl/conv1d_compute_engine_mac_lane.sv
// Product and sum/round/saturate stages of the convolution pipeline, carrying
// valid and (filter, position) along. CONV_RELU_EN clamps negative results to 0.
module conv_mac_lane
    import conv_pkg::*;
#(
    parameter int BIT_WIDTH   = DEF_BIT_WIDTH,
    parameter int FRAC_BITS   = DEF_FRAC_BITS,
    parameter int KERNEL_TAPS = DEF_KERNEL_TAPS,
    parameter int FAW         = 3,
    parameter int PAW         = 9
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 in_v_i,
    input  logic [FAW-1:0]                       in_f_i,
    input  logic [PAW-1:0]                       in_p_i,
    input  logic [KERNEL_TAPS*BIT_WIDTH-1:0]     data_i,
    input  logic [(KERNEL_TAPS+1)*BIT_WIDTH-1:0] weight_i,
    output logic                                 out_v_o,
    output logic [FAW-1:0]                       out_f_o,
    output logic [PAW-1:0]                       out_p_o,
    output logic [BIT_WIDTH-1:0]                 out_data_o
);
    localparam int PW    = 2 * BIT_WIDTH;
    localparam int ACC_W = acc_width(BIT_WIDTH, KERNEL_TAPS);

    logic signed [PW-1:0]        prod_d [KERNEL_TAPS];
    logic signed [PW-1:0]        prod_q [KERNEL_TAPS];
    logic signed [BIT_WIDTH-1:0] bias_q;
    logic                        prod_v_q;
    logic [FAW-1:0]              prod_f_q;
    logic [PAW-1:0]              prod_p_q;

    logic signed [ACC_W-1:0]     acc;
    logic signed [BIT_WIDTH-1:0] res_d;
    logic                        out_v_q;
    logic [FAW-1:0]              out_f_q;
    logic [PAW-1:0]              out_p_q;
    logic [BIT_WIDTH-1:0]        out_data_q;

    always_comb begin
        for (int k = 0; k < KERNEL_TAPS; k++) begin
            prod_d[k] = PW'($signed(data_i[k*BIT_WIDTH +: BIT_WIDTH]))
                      * PW'($signed(weight_i[(k+1)*BIT_WIDTH +: BIT_WIDTH]));
        end
    end

    // Bias is aligned to the product's Q position before summing.
    always_comb begin
        acc = ACC_W'(bias_q) <<< FRAC_BITS;
        for (int k = 0; k < KERNEL_TAPS; k++) begin
            acc = acc + ACC_W'(prod_q[k]);
        end
        res_d = BIT_WIDTH'(sat_shift(WIDE_W'(acc), BIT_WIDTH, FRAC_BITS));
`ifdef CONV_RELU_EN
        if (res_d[BIT_WIDTH-1]) begin
            res_d = '0;
        end
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int k = 0; k < KERNEL_TAPS; k++) begin
                prod_q[k] <= '0;
            end
            bias_q     <= '0;
            prod_v_q   <= 1'b0;
            prod_f_q   <= '0;
            prod_p_q   <= '0;
            out_v_q    <= 1'b0;
            out_f_q    <= '0;
            out_p_q    <= '0;
            out_data_q <= '0;
        end else begin
            for (int k = 0; k < KERNEL_TAPS; k++) begin
                prod_q[k] <= prod_d[k];
            end
            bias_q     <= weight_i[BIT_WIDTH-1:0];
            prod_v_q   <= in_v_i;
            prod_f_q   <= in_f_i;
            prod_p_q   <= in_p_i;
            out_v_q    <= prod_v_q;
            out_f_q    <= prod_f_q;
            out_p_q    <= prod_p_q;
            out_data_q <= res_d;
        end
    end

    assign out_v_o    = out_v_q;
    assign out_f_o    = out_f_q;
    assign out_p_o    = out_p_q;
    assign out_data_o = out_data_q;

endmodule

// File: rtl/conv1d_compute_engine.sv
// Sequencer and RAM-facing pipeline of the 1-D convolution layer engine.
// Build option CONV_RELU_EN enables the fused ReLU inside conv_mac_lane.
//
// state | meaning
// IDLE  | waiting for start; counts latched on start
// RUN   | one (position, filter) read per cycle, filter innermost
// DRAIN | reads stopped, waiting for the last result to reach the output stage
// DONE  | one cycle before the done pulse, then back to IDLE
module conv1d_compute_engine
    import conv_pkg::*;
#(
    parameter int BIT_WIDTH   = DEF_BIT_WIDTH,
    parameter int FRAC_BITS   = DEF_FRAC_BITS,
    parameter int KERNEL_TAPS = DEF_KERNEL_TAPS,
    parameter int NUM_FILTERS = DEF_NUM_FILTERS,
    parameter int DATA_DEPTH  = DEF_DATA_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    conv1d_compute_engine_if.slave bus_if
);
    localparam int PAW = $clog2(DATA_DEPTH);
    localparam int PCW = PAW + 1;
    localparam int FAW = $clog2(NUM_FILTERS);
    localparam int FCW = FAW + 1;

    state_t         state_q, state_d;
    logic [PCW-1:0] np_q, np_d, np_clamp;
    logic [FCW-1:0] nf_q, nf_d, nf_clamp;
    logic [PAW-1:0] p_q, p_d;
    logic [FAW-1:0] f_q, f_d;
    logic           rd_en_q, rd_en_d;
    logic           last_issue;
    logic           done_q;

    logic                                 ram_v_q;
    logic [FAW-1:0]                       ram_f_q;
    logic [PAW-1:0]                       ram_p_q;
    logic                                 cap_v_q;
    logic [FAW-1:0]                       cap_f_q;
    logic [PAW-1:0]                       cap_p_q;
    logic [KERNEL_TAPS*BIT_WIDTH-1:0]     cap_data_q;
    logic [(KERNEL_TAPS+1)*BIT_WIDTH-1:0] cap_wt_q;

    always_comb begin
        np_clamp = (bus_if.num_positions > PCW'(DATA_DEPTH)) ? PCW'(DATA_DEPTH)
                                                              : bus_if.num_positions;
        nf_clamp = (bus_if.num_filters > FCW'(NUM_FILTERS)) ? FCW'(NUM_FILTERS)
                                                             : bus_if.num_filters;
    end

    assign last_issue = (FCW'(f_q) == nf_q - FCW'(1)) && (PCW'(p_q) == np_q - PCW'(1));

    always_comb begin
        state_d = state_q;
        np_d    = np_q;
        nf_d    = nf_q;
        p_d     = p_q;
        f_d     = f_q;
        rd_en_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus_if.start) begin
                    np_d = np_clamp;
                    nf_d = nf_clamp;
                    p_d  = '0;
                    f_d  = '0;
                    if (np_clamp == '0 || nf_clamp == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        rd_en_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (last_issue) begin
                    state_d = DRAIN;
                    p_d     = '0;
                    f_d     = '0;
                end else begin
                    rd_en_d = 1'b1;
                    if (FCW'(f_q) == nf_q - FCW'(1)) begin
                        f_d = '0;
                        p_d = p_q + PAW'(1);
                    end else begin
                        f_d = f_q + FAW'(1);
                    end
                end
            end
            // Leave once the last item is in the product stage; done is
            // registered, so it lands the cycle after the final write.
            DRAIN: begin
                if (!ram_v_q && !cap_v_q) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            np_q       <= '0;
            nf_q       <= '0;
            p_q        <= '0;
            f_q        <= '0;
            rd_en_q    <= 1'b0;
            done_q     <= 1'b0;
            ram_v_q    <= 1'b0;
            ram_f_q    <= '0;
            ram_p_q    <= '0;
            cap_v_q    <= 1'b0;
            cap_f_q    <= '0;
            cap_p_q    <= '0;
            cap_data_q <= '0;
            cap_wt_q   <= '0;
        end else begin
            state_q    <= state_d;
            np_q       <= np_d;
            nf_q       <= nf_d;
            p_q        <= p_d;
            f_q        <= f_d;
            rd_en_q    <= rd_en_d;
            done_q     <= (state_q == DONE);
            ram_v_q    <= rd_en_q;
            ram_f_q    <= f_q;
            ram_p_q    <= p_q;
            cap_v_q    <= ram_v_q;
            cap_f_q    <= ram_f_q;
            cap_p_q    <= ram_p_q;
            cap_data_q <= bus_if.data_read_out;
            cap_wt_q   <= bus_if.weight_read_out;
        end
    end

    assign bus_if.data_ram_address    = p_q;
    assign bus_if.data_ram_read_en    = rd_en_q;
    assign bus_if.weights_ram_address = f_q;
    assign bus_if.weights_ram_read_en = rd_en_q;
    assign bus_if.busy                = (state_q != IDLE);
    assign bus_if.done                = done_q;

    conv_mac_lane #(
        .BIT_WIDTH   (BIT_WIDTH),
        .FRAC_BITS   (FRAC_BITS),
        .KERNEL_TAPS (KERNEL_TAPS),
        .FAW         (FAW),
        .PAW         (PAW)
    ) u_mac_lane (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .in_v_i     (cap_v_q),
        .in_f_i     (cap_f_q),
        .in_p_i     (cap_p_q),
        .data_i     (cap_data_q),
        .weight_i   (cap_wt_q),
        .out_v_o    (bus_if.result_ram_write_en),
        .out_f_o    (bus_if.result_ram_write_address_depth),
        .out_p_o    (bus_if.result_ram_write_address_width),
        .out_data_o (bus_if.result_ram_write_data)
    );

endmodule

// File: tb/tb_conv1d_compute_engine.sv
// Randomized bench for conv1d_compute_engine with behavioural RAMs and a
// queue-based reference of the convolution layer.
module tb_conv1d_compute_engine;
    localparam int BW   = 16;
    localparam int FRAC = 8;
    localparam int K    = 5;
    localparam int NF   = 8;
    localparam int DD   = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv1d_compute_engine_if #(.BIT_WIDTH(BW), .KERNEL_TAPS(K),
                               .NUM_FILTERS(NF), .DATA_DEPTH(DD)) bus ();

    conv1d_compute_engine #(.BIT_WIDTH(BW), .FRAC_BITS(FRAC), .KERNEL_TAPS(K),
                            .NUM_FILTERS(NF), .DATA_DEPTH(DD)) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus_if (bus)
    );

    typedef struct {
        int     f;
        int     p;
        longint d;
    } wr_t;

    int     x [DD+K];
    int     w [NF][K+1];
    wr_t    exp_q [$];
    wr_t    mon_e;
    int     n_vec = 0;
    int     n_err = 0;
    longint cyc = 0;
    int     wr_cnt = 0;
    int     done_cnt = 0;
    longint first_wr_cyc = 0;
    longint last_wr_data = 0;

    task automatic check_val(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [K*BW-1:0] window(input int p);
        logic [K*BW-1:0] v;
        for (int k = 0; k < K; k++) v[k*BW +: BW] = BW'(x[p+k]);
        return v;
    endfunction

    function automatic logic [(K+1)*BW-1:0] wrow(input int f);
        logic [(K+1)*BW-1:0] v;
        for (int k = 0; k <= K; k++) v[k*BW +: BW] = BW'(w[f][k]);
        return v;
    endfunction

    function automatic longint ref_val(input int p, input int f);
        longint acc;
        acc = longint'(w[f][0]) * (64'sd1 <<< FRAC);
        for (int k = 0; k < K; k++) acc += longint'(x[p+k]) * longint'(w[f][k+1]);
        acc = acc >>> FRAC;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
`ifdef CONV_RELU_EN
        if (acc < 0) acc = 0;
`endif
        return acc;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        if (rst) begin
            bus.data_read_out   <= '0;
            bus.weight_read_out <= '0;
        end else begin
            if (bus.data_ram_read_en)
                bus.data_read_out <= window(int'(bus.data_ram_address));
            if (bus.weights_ram_read_en)
                bus.weight_read_out <= wrow(int'(bus.weights_ram_address));
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.done === 1'b1) done_cnt++;
            if (bus.result_ram_write_en === 1'b1) begin
                if (wr_cnt == 0) first_wr_cyc = cyc;
                wr_cnt++;
                last_wr_data = longint'($signed(bus.result_ram_write_data));
                if (exp_q.size() == 0) begin
                    check_val("unexpected_write", 1, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check_val("wr_addr",
                              {bus.result_ram_write_address_depth, bus.result_ram_write_address_width},
                              mon_e.f * DD + mon_e.p);
                    check_val("wr_data", $signed(bus.result_ram_write_data), mon_e.d);
                end
            end
        end
    end

    task automatic build_exp(input int np, input int nf);
        exp_q.delete();
        for (int p = 0; p < np; p++)
            for (int f = 0; f < nf; f++)
                exp_q.push_back('{f: f, p: p, d: ref_val(p, f)});
    endtask

    task automatic fill_random();
        for (int i = 0; i < DD + K; i++) x[i] = int'($urandom_range(0, 2047)) - 1024;
        for (int f = 0; f < NF; f++)
            for (int k = 0; k <= K; k++) w[f][k] = int'($urandom_range(0, 2047)) - 1024;
    endtask

    task automatic fill_const(input int xv, input int wv, input int bv);
        for (int i = 0; i < DD + K; i++) x[i] = xv;
        for (int f = 0; f < NF; f++) begin
            w[f][0] = bv;
            for (int k = 1; k <= K; k++) w[f][k] = wv;
        end
    endtask

    task automatic run(input int np_in, input int nf_in, input bit restart_mid);
        int     np_eff, nf_eff, n;
        longint t0, exp_done;
        np_eff = (np_in > DD) ? DD : np_in;
        nf_eff = (nf_in > NF) ? NF : nf_in;
        n = np_eff * nf_eff;
        exp_done = (n == 0) ? 2 : longint'(n + 5);
        build_exp(np_eff, nf_eff);
        @(negedge clk);
        wr_cnt = 0;
        done_cnt = 0;
        bus.start = 1'b1;
        bus.num_positions = 10'(np_in);
        bus.num_filters = 4'(nf_in);
        t0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        check_val("busy_after_start", bus.busy, 1);
        if (restart_mid) begin
            bus.start = 1'b1;
            bus.num_positions = 10'd1;
            bus.num_filters = 4'd1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        while (bus.done !== 1'b1 && (cyc - t0) < exp_done + 20) @(negedge clk);
        check_val("done_cycle", cyc - t0, exp_done);
        check_val("busy_at_done", bus.busy, 0);
        if (n > 0) check_val("first_write_latency", first_wr_cyc - t0, 5);
        repeat (8) @(negedge clk);
        check_val("write_count", wr_cnt, n);
        check_val("missing_writes", exp_q.size(), 0);
        check_val("done_pulses", done_cnt, 1);
        check_val("idle_read_en", bus.data_ram_read_en, 0);
    endtask

    task automatic check_quiet(input string tag);
        check_val({tag, "_busy"}, bus.busy, 0);
        check_val({tag, "_done"}, bus.done, 0);
        check_val({tag, "_wr_en"}, bus.result_ram_write_en, 0);
        check_val({tag, "_rd_en"}, {bus.data_ram_read_en, bus.weights_ram_read_en}, 0);
        check_val({tag, "_addr"}, {bus.data_ram_address, bus.weights_ram_address}, 0);
        check_val({tag, "_wr_data"}, {bus.result_ram_write_data,
                  bus.result_ram_write_address_depth, bus.result_ram_write_address_width}, 0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.num_positions = '0;
        bus.num_filters = '0;
        fill_const(256, 256, 128);
        repeat (2) @(negedge clk);
        check_quiet("reset");
        rst = 1'b0;

        run(1, 1, 1'b0);
        check_val("unity_result", last_wr_data, 64'sh580);

        fill_random();
        run(3, 2, 1'b0);
        for (int i = 0; i < 4; i++)
            run(int'($urandom_range(1, 24)), int'($urandom_range(1, 8)), i == 2);
        run(3, 12, 1'b0);

        fill_const(32767, 32767, 32767);
        run(1, 1, 1'b0);
        check_val("sat_pos", last_wr_data, 32767);
        fill_const(32767, -32767, 32767);
        run(1, 1, 1'b0);
`ifdef CONV_RELU_EN
        check_val("sat_neg_relu", last_wr_data, 0);
`else
        check_val("sat_neg", last_wr_data, -32768);
`endif

        run(0, 3, 1'b1);
        run(4, 0, 1'b0);

        fill_random();
        build_exp(10, 4);
        @(negedge clk);
        bus.start = 1'b1;
        bus.num_positions = 10'd10;
        bus.num_filters = 4'd4;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_quiet("mid_reset");
        exp_q.delete();
        rst = 1'b0;
        run(5, 3, 1'b0);

        run(600, 8, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/conv1d_compute_engine.md
# conv1d_compute_engine

Parametrised successor to the fixed 5-tap convolution pipeline of the ECG classifier. It computes one signed fixed-point 1-D convolution layer with a bias per filter. An internal FSM sequences the work; there is no instruction ROM. Tap count, filter count, depth and fraction bits are compile-time parameters, and the active position/filter counts are runtime inputs. The block sits between the data/weight RAMs and the result RAM and is launched by the layer controller with a Start pulse.

## Interface
- BIT_WIDTH, 16, signed word width of data, weights, bias and result
- FRAC_BITS, 8, fractional bits of the Q format; must be less than BIT_WIDTH
- KERNEL_TAPS, 5, taps per filter (1..16)
- NUM_FILTERS, 8, maximum filters; sets weight RAM depth
- DATA_DEPTH, 512, maximum output positions; sets data/result width address
- Clk  in  1  clock; all logic is on the rising edge
- Reset  in  1  synchronous, active-high
- Start  in  1  one-cycle launch pulse; ignored unless IDLE
- Num_positions  in  $clog2(DATA_DEPTH)+1  output positions, latched at Start
- Num_filters  in  $clog2(NUM_FILTERS)+1  active filters, latched at Start
- Data_RAM_address  out  $clog2(DATA_DEPTH)  window base position
- Data_RAM_read_en  out  1  data RAM read strobe
- Data_read_out  in  KERNEL_TAPS*BIT_WIDTH  tap window; tap k is at [k*BIT_WIDTH +: BIT_WIDTH]
- Weights_RAM_address  out  $clog2(NUM_FILTERS)  filter index
- Weights_RAM_read_en  out  1  weight RAM read strobe
- Weight_read_out  in  (KERNEL_TAPS+1)*BIT_WIDTH  slice 0 is the bias; slices 1..K are the tap weights
- Result_RAM_write_en  out  1  write strobe
- Result_RAM_write_address_depth  out  $clog2(NUM_FILTERS)  filter
- Result_RAM_write_address_width  out  $clog2(DATA_DEPTH)  position
- Result_RAM_write_data  out  BIT_WIDTH  saturated result
- Busy  out  1  high from the cycle after Start until the cycle Done is high
- Done  out  1  one-cycle completion pulse

## Operation
- FSM states:
  - IDLE: on Start, latch the counts. If either count is 0, go to DONE; otherwise go to RUN.
  - RUN: issue one read per cycle. Filter index f is the inner loop (0..Nf-1) and position p is the outer loop (0..Np-1). After issuing the last (p, f), go to DRAIN.
  - DRAIN: wait until the pipeline empties, then go to DONE.
  - DONE: pulse Done, then return to IDLE.
- Counts larger than the parameter maxima are clamped to DATA_DEPTH / NUM_FILTERS.
- Datapath stages: address/read-enable register → capture of RAM outputs → registered products → registered sum/round/saturate → result write.
- Products are signed BIT_WIDTH×BIT_WIDTH, giving 2*BIT_WIDTH bits.
- Accumulator width is 2*BIT_WIDTH + $clog2(KERNEL_TAPS+1). The accumulator is the sum of all tap products plus (bias <<< FRAC_BITS).
- Result is acc >>> FRAC_BITS (arithmetic shift, truncation toward −∞), then saturated to [−2^(BIT_WIDTH−1), 2^(BIT_WIDTH−1)−1].
- The write address (f, p) travels through the pipeline with its data; it is never recomputed.

## Timing
- Reset: every output is 0, the FSM goes to IDLE, all pipeline valid bits clear, and any in-flight write is discarded. Reset wins over a simultaneous Start.
- RAM read latency is exactly 1 cycle.
- Address-to-write latency: Result_RAM_write_en rises exactly 4 cycles after the cycle in which the matching address and read-enable are driven.
- Throughput: 1 result per cycle.
- First address appears 1 cycle after Start.
- Done is high exactly 1 cycle after the last Result_RAM_write_en cycle. Total cycles from Start to Done = Np*Nf + 5.
- Zero-count run: Done is asserted 2 cycles after Start and no writes occur.
- Start while Busy has no effect.
- Read enables are low in IDLE, DRAIN and DONE.

## Configuration
- CONV_RELU_EN defined: after saturation, negative results are written as 0 (fused ReLU); latency is unchanged.
- CONV_RELU_EN undefined: the signed saturated result is written as-is.

## Structure
- Package conv_pkg:
  - FSM state enum (IDLE, RUN, DRAIN, DONE)
  - helper constants: accumulator width, saturation max/min
  - function sat_shift(acc) performing the shift and saturation
- Sub-module conv_mac_lane, instantiated once: registered multiply of all taps, then registered adder tree, rounding, saturation and optional ReLU. It carries the valid bit and address sideband.

## Test plan
- Defaults, Np=1, Nf=1, data all 0x0100 (1.0), weights 0x0100, bias 0x0080 → one write of 0x0580 at depth 0, width 0; Done at Start+6.
- Np=3, Nf=2, random data/weights → 6 writes in order (0,0),(1,0),(0,1),(1,1),(0,2),(1,2) as (f,p), matching the golden model bit-exactly.
- Data 0x7FFF, weights 0x7FFF, bias 0x7FFF → 0x7FFF; negated weights → 0x8000 without CONV_RELU_EN and 0x0000 with it.
- Np=0 → Busy high for 1 cycle, Done at Start+2, zero writes; a Start during Busy is ignored (no extra Done).
- Reset asserted mid-RUN → next cycle all outputs are 0 and the FSM is IDLE; a new Start then completes a full run correctly.
- Np=600 (clamped to 512), Nf=8 → 4096 writes, the width address never wraps, Done at Start+4101.
